// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with synchronous load, wrap or saturate at the limits,
// a combinational terminal-count flag and a registered one-cycle limit-event pulse.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic             SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;

    // Next-state: load beats enable; limit steps either wrap or hold and always flag ovf
    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count == MAX_CNT) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = SAT ? MAX_CNT : '0;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = SAT ? '0 : MAX_CNT;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign tc = (up_dn & (count == MAX_CNT)) | (~up_dn & (count == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four parameterisations share one stimulus stream and are
// checked every cycle against an integer model, plus hand-computed spot values.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [7:0] lv;
    logic [3:0] c0, c1, c2;
    logic [7:0] c3;
    logic       tc0, tc1, tc2, tc3;
    logic       o0, o1, o2, o3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .count(c0), .tc(tc0), .ovf(o0));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .count(c1), .tc(tc1), .ovf(o1));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .count(c2), .tc(tc2), .ovf(o2));
    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv), .count(c3), .tc(tc3), .ovf(o3));

    // Model state per instance: plain integers over the legal range 0..mod-1
    int  mods [4] = '{16, 10, 10, 256};
    int  sats [4] = '{0, 0, 1, 0};
    int  lvmask [4] = '{15, 15, 15, 255};
    int  mcnt [4] = '{0, 0, 0, 0};
    int  movf [4] = '{0, 0, 0, 0};
    bit  armed = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int v;
            if (reset) begin
                mcnt[i] = 0;
                movf[i] = 0;
            end else if (load) begin
                v = int'(lv) & lvmask[i];
                mcnt[i] = (v >= mods[i]) ? mods[i] - 1 : v;
                movf[i] = 0;
            end else if (en) begin
                v = up_dn ? mcnt[i] + 1 : mcnt[i] - 1;
                if (v == mods[i] || v < 0) begin
                    movf[i] = 1;
                    if (sats[i] == 0) mcnt[i] = (v < 0) ? mods[i] - 1 : 0;
                end else begin
                    movf[i] = 0;
                    mcnt[i] = v;
                end
            end else begin
                movf[i] = 0;
            end
        end
        if (reset) armed = 1'b1;
    end

    function automatic int exp_tc(input int i);
        return up_dn ? int'(mcnt[i] == mods[i] - 1) : int'(mcnt[i] == 0);
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            check("cnt0", int'(c0), mcnt[0]); check("ovf0", int'(o0), movf[0]); check("tc0", int'(tc0), exp_tc(0));
            check("cnt1", int'(c1), mcnt[1]); check("ovf1", int'(o1), movf[1]); check("tc1", int'(tc1), exp_tc(1));
            check("cnt2", int'(c2), mcnt[2]); check("ovf2", int'(o2), movf[2]); check("tc2", int'(tc2), exp_tc(2));
            check("cnt3", int'(c3), mcnt[3]); check("ovf3", int'(o3), movf[3]); check("tc3", int'(tc3), exp_tc(3));
        end
    end

    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [7:0] v, input int n);
        reset = r; en = e; up_dn = u; load = l; lv = v;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b1; lv = 8'd5;
        @(posedge clk); #1;
        // Reset overrides load and en
        check("rst_cnt0", int'(c0), 0);
        check("rst_ovf0", int'(o0), 0);
        check("rst_tc_dn", int'(tc0), 1);
        up_dn = 1'b1; #1;
        check("rst_tc_up", int'(tc0), 0);

        // Default counter: 0..15 then wrap with one ovf pulse
        step(0, 1, 1, 0, 0, 15);
        check("up15_cnt0", int'(c0), 15);
        check("up15_tc0", int'(tc0), 1);
        check("up15_sat", int'(c2), 9);
        step(0, 1, 1, 0, 0, 1);
        check("wrap_cnt0", int'(c0), 0);
        check("wrap_ovf0", int'(o0), 1);
        check("wrap_cnt1", int'(c1), 6);
        step(0, 1, 1, 0, 0, 1);
        check("up17_cnt0", int'(c0), 1);
        check("up17_ovf0", int'(o0), 0);
        check("up17_cnt1", int'(c1), 7);

        // Modulus 10 wrap and saturate, direction change at the limit
        step(1, 0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 9);
        check("m10_cnt9", int'(c1), 9);
        check("m10_ovf_pre", int'(o1), 0);
        step(0, 1, 1, 0, 0, 1);
        check("m10_wrap", int'(c1), 0);
        check("m10_wrap_ovf", int'(o1), 1);
        check("sat_hold", int'(c2), 9);
        check("sat_ovf10", int'(o2), 1);
        step(0, 1, 1, 0, 0, 2);
        check("sat_ovf12", int'(o2), 1);
        step(1, 0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("m10_under", int'(c1), 9);
        check("m10_under_ovf", int'(o1), 1);
        check("sat_low", int'(c2), 0);
        check("sat_low_ovf", int'(o2), 1);
        step(0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 2);
        check("hold_cnt1", int'(c1), 6);
        check("hold_ovf1", int'(o1), 0);

        // Load clamps above the modulus and beats en
        step(0, 0, 1, 1, 8'd12, 1);
        check("ld_clamp", int'(c1), 9);
        check("ld_noclamp", int'(c0), 12);
        step(0, 1, 1, 1, 8'd3, 1);
        check("ld_wins", int'(c1), 3);
        check("ld_ovf", int'(o1), 0);

        // Reset mid-count, then resume from 0
        step(1, 0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 7);
        check("mid_cnt7", int'(c0), 7);
        reset = 1'b1; #3;
        check("async_none", int'(c0), 7);
        reset = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 1, 1, 8'd4, 1);
        check("mid_rst", int'(c0), 0);
        check("mid_rst_ovf", int'(o0), 0);
        step(0, 1, 1, 0, 0, 1);
        check("resume1", int'(c0), 1);
        step(0, 1, 1, 0, 0, 1);
        check("resume2", int'(c0), 2);

        // 8-bit full-range counter down from reset
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("w8_255", int'(c3), 255);
        check("w8_ovf", int'(o3), 1);
        step(0, 1, 0, 0, 0, 255);
        check("w8_zero", int'(c3), 0);
        check("w8_tc", int'(tc3), 1);
        check("w8_ovf_off", int'(o3), 0);

        step(0, 0, 0, 0, 0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of the count value.
REQ-002 Parameter MODULUS, default 16, number of count states (0..MODULUS-1); legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; one step per clk edge while high.
REQ-007 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value captured on load.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 tc  output  1  terminal count flag, combinational from count and up_dn.
REQ-012 ovf  output  1  registered one-cycle overflow/underflow event pulse.

Function
REQ-013 Per-edge priority SHALL be: reset > load > en > hold.
REQ-014 load=1: count <= load_val if load_val < MODULUS, else count <= MODULUS-1 (clamp); en and up_dn ignored that cycle; ovf <= 0.
REQ-015 en=1, load=0, up_dn=1, count < MODULUS-1: count <= count+1; ovf <= 0.
REQ-016 en=1, load=0, up_dn=0, count > 0: count <= count-1; ovf <= 0.
REQ-017 Up step at count = MODULUS-1: SATURATE=0 -> count <= 0; SATURATE=1 -> count holds MODULUS-1; ovf <= 1 in both modes.
REQ-018 Down step at count = 0: SATURATE=0 -> count <= MODULUS-1; SATURATE=1 -> count holds 0; ovf <= 1 in both modes.
REQ-019 en=0, load=0: count holds; ovf <= 0.
REQ-020 ovf SHALL be high for exactly one cycle per limit event; back-to-back enabled steps at a held limit (SATURATE=1) SHALL keep ovf high on each such cycle.
REQ-021 tc = (up_dn & count==MODULUS-1) | (~up_dn & count==0), independent of en and load.
REQ-022 Count arithmetic SHALL use MODULUS-1 as the limit, never 2**WIDTH-1, when MODULUS < 2**WIDTH; count SHALL never hold a value >= MODULUS.
REQ-023 Direction change SHALL take effect on the same edge as the step; no extra latency.
REQ-024 Latency: count and ovf reflect inputs sampled at edge N from edge N onward (one register stage); no pipeline.

Reset
REQ-025 reset=1 at a clk edge SHALL set count <= 0 and ovf <= 0, overriding load and en.
REQ-026 After reset, with up_dn=0, tc SHALL read 1 (count=0); with up_dn=1, tc SHALL read 0.
REQ-027 Reset asserted mid-count SHALL take effect on the next edge with no partial-step residue; counting resumes from 0 on the first edge with reset=0 and en=1.
REQ-028 No asynchronous reset path SHALL exist; reset between edges SHALL not change outputs.

Verification
REQ-029 Defaults (4/16/0): reset 1 cycle, en=1, up_dn=1 for 17 edges -> count 0,1,...,15,0,1; tc high while count=15; ovf high exactly the cycle count=0 after 15.
REQ-030 MODULUS=10, SATURATE=0: up from 0 -> count 9 then 0, ovf one cycle; switch up_dn=0 at 0 -> count 9, ovf one cycle.
REQ-031 MODULUS=10, SATURATE=1: up for 12 edges -> count sticks at 9, ovf high on the 10th and 11th/12th edges; down for 11 edges -> sticks at 0, ovf high at each blocked step.
REQ-032 load=1, load_val=12 with MODULUS=10 -> count=9; load=1, en=1, up_dn=1, load_val=3 -> count=3 (load wins).
REQ-033 Count to 7, assert reset with load=1, en=1 -> count=0, ovf=0 next edge; release -> 1,2,3...
REQ-034 WIDTH=8, MODULUS=256, down from reset -> count 255, ovf pulse; 255 edges later count=0, tc=1.
